// File: rtl/fir_band_scheduler_if.sv
// Sample, coefficient-ROM and band-result signals between the sample source and
// fir_band_scheduler. The scheduler uses the slave modport; the source/ROM side uses master.
interface fir_band_scheduler_if #(
    parameter int unsigned DW     = 10,
    parameter int unsigned BAND_W = 2,
    parameter int unsigned TAP_W  = 5
);
    logic                      sample_valid;
    logic [DW-1:0]             sample_in;
    logic [BAND_W+TAP_W-1:0]   coef_addr;
    logic [DW-1:0]             coef_data;
    logic                      busy;
    logic [DW-1:0]             band_out;
    logic [BAND_W-1:0]         band_id;
    logic                      out_valid;
    logic                      overrun;

    modport master (
        output sample_valid, sample_in, coef_data,
        input  coef_addr, busy, band_out, band_id, out_valid, overrun
    );

    modport slave (
        input  sample_valid, sample_in, coef_data,
        output coef_addr, busy, band_out, band_id, out_valid, overrun
    );
endinterface

// File: rtl/fir_band_scheduler.sv
// Time-shared serial-MAC sequencer for the 4-band sign-magnitude FIR bank.
// Define FIR_SCHED_SAT_EN to saturate band_out magnitudes above 511 instead of wrapping them.
module fir_band_scheduler #(
    parameter int unsigned ORDER  = 30,
    parameter int unsigned NBANDS = 4,
    parameter int unsigned DW     = 10,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned TAP_W  = 5,
    parameter int unsigned BAND_W = 2
) (
    input  logic                 clk_slow,
    input  logic                 rst,
    fir_band_scheduler_if.slave  io_bus
);
    localparam int unsigned MW      = DW - 1;
    localparam int unsigned PW      = 2 * MW;
    localparam int unsigned MAG_MAX = (2 ** MW) - 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MAC  = 2'b01;
    localparam logic [1:0] S_OUT  = 2'b10;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DW-1:0]     r_hist [ORDER];
    logic [TAP_W-1:0]  r_wr_ptr;
    logic [TAP_W-1:0]  r_tap;
    logic [BAND_W-1:0] r_band;
    logic [ACC_W-1:0]  r_acc;
    logic              r_busy;
    logic              r_out_valid;
    logic              r_overrun;
    logic [DW-1:0]     r_band_out;
    logic [BAND_W-1:0] r_band_id;

    logic              w_accept;
    logic              w_last_tap;
    logic              w_last_band;
    logic [DW-1:0]     w_sample;
    logic [TAP_W-1:0]  w_idx;
    logic [DW-1:0]     w_x;
    logic [PW-1:0]     w_prod;
    logic [MW-1:0]     w_pmag;
    logic [ACC_W-1:0]  w_term;
    logic [ACC_W-1:0]  w_mag;
    logic [MW-1:0]     w_out_mag;
    logic              w_out_sign;

    assign w_last_tap  = (r_tap == TAP_W'(ORDER - 1));
    assign w_last_band = (r_band == BAND_W'(NBANDS - 1));
    assign w_sample    = (io_bus.sample_in[MW-1:0] == '0) ? '0 : io_bus.sample_in;

    // Newest sample sits at wr_ptr; modular subtract stays correct for non-power-of-two ORDER
    assign w_idx  = (r_wr_ptr >= r_tap) ? (r_wr_ptr - r_tap)
                                        : (r_wr_ptr + TAP_W'(ORDER) - r_tap);
    assign w_x    = r_hist[w_idx];
    assign w_prod = PW'(w_x[MW-1:0]) * PW'(io_bus.coef_data[MW-1:0]);
    assign w_pmag = MW'(w_prod >> MW);
    assign w_term = (w_x[DW-1] ^ io_bus.coef_data[DW-1]) ? (ACC_W'(0) - ACC_W'(w_pmag))
                                                         : ACC_W'(w_pmag);

    assign w_mag  = r_acc[ACC_W-1] ? (ACC_W'(0) - r_acc) : r_acc;
`ifdef FIR_SCHED_SAT_EN
    assign w_out_mag = (w_mag > ACC_W'(MAG_MAX)) ? MW'(MAG_MAX) : MW'(w_mag);
`else
    assign w_out_mag = MW'(w_mag);
`endif
    assign w_out_sign = r_acc[ACC_W-1] && (w_out_mag != '0);

    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.sample_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC:   if (w_last_tap) w_state_nxt = S_OUT;
            S_OUT:   w_state_nxt = w_last_band ? S_IDLE : S_MAC;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // History buffer, MAC datapath and registered outputs
    always_ff @(posedge clk_slow or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ORDER; i++) r_hist[TAP_W'(i)] <= '0;
            r_wr_ptr    <= '0;
            r_tap       <= '0;
            r_band      <= '0;
            r_acc       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
            r_band_out  <= '0;
            r_band_id   <= '0;
        end else begin
            r_out_valid <= 1'b0;
            r_overrun   <= io_bus.sample_valid && (r_state != S_IDLE);
            r_busy      <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hist[r_wr_ptr] <= w_sample;
                        r_band           <= '0;
                        r_tap            <= '0;
                        r_acc            <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + w_term;
                    r_tap <= w_last_tap ? '0 : (r_tap + TAP_W'(1));
                end
                S_OUT: begin
                    r_out_valid <= 1'b1;
                    r_band_id   <= r_band;
                    r_band_out  <= {w_out_sign, w_out_mag};
                    r_acc       <= '0;
                    r_tap       <= '0;
                    r_band      <= r_band + BAND_W'(1);
                    if (w_last_band)
                        r_wr_ptr <= (r_wr_ptr == TAP_W'(ORDER - 1)) ? '0 : (r_wr_ptr + TAP_W'(1));
                end
                default: ;
            endcase
        end
    end

    assign io_bus.coef_addr = {r_band, r_tap};
    assign io_bus.busy      = r_busy;
    assign io_bus.band_out  = r_band_out;
    assign io_bus.band_id   = r_band_id;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.overrun   = r_overrun;
endmodule
